// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin arbiter sharing one magnitude comparator among N requesters.
// Optional CMP_CHECK_EN adds a sticky cmp_err output that flags bad comparator results.
module compare_arbiter #(
    parameter int WIDTH = 4,
    parameter int N = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*WIDTH-1:0] req_a,
    input  logic [N*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    output logic             cmp_en,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDW-1:0]   resp_id,
    output logic             resp_eq,
    output logic             resp_gt,
    output logic             resp_lt
`ifdef CMP_CHECK_EN
    ,
    output logic             cmp_err
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state;
    logic [IDW-1:0] rr_ptr, grant_id, win, idx;
    logic hit;
    logic [N-1:0] one_hot;
    logic [WIDTH-1:0] a_arr [N];
    logic [WIDTH-1:0] b_arr [N];
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end
    // Scan from the farthest offset back to rr_ptr so the nearest valid requester wins.
    always_comb begin
        win = '0;
        idx = '0;
        hit = 1'b0;
        one_hot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IDW'((int'(rr_ptr) + i) % N);
            if (req_valid[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
        one_hot[win] = hit;
    end
    assign req_ready = (state == IDLE && !rst) ? one_hot : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant_id <= '0;
            cmp_a <= '0;
            cmp_b <= '0;
            cmp_en <= 1'b0;
            resp_valid <= 1'b0;
            resp_id <= '0;
            resp_eq <= 1'b0;
            resp_gt <= 1'b0;
            resp_lt <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hit) begin
                    cmp_a <= a_arr[win];
                    cmp_b <= b_arr[win];
                    grant_id <= win;
                    rr_ptr <= (win == IDW'(N - 1)) ? '0 : win + 1'b1;
                    cmp_en <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    resp_eq <= cmp_eq;
                    resp_gt <= cmp_gt;
                    resp_lt <= cmp_lt;
                    resp_id <= grant_id;
                    resp_valid <= 1'b1;
                    cmp_en <= 1'b0;
                    state <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef CMP_CHECK_EN
    // The reference compare is one-hot, so any mismatch also covers non-one-hot flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cmp_err <= 1'b0;
        else if (state == ISSUE && {cmp_eq, cmp_gt, cmp_lt} != {cmp_a == cmp_b, cmp_a > cmp_b, cmp_a < cmp_b})
            cmp_err <= 1'b1;
    end
`endif
endmodule

// File: doc/compare_arbiter.md
Name: compare_arbiter

Overview:
- Round-robin arbiter that shares one 4-bit magnitude comparator (enable input; eq/greater/lesser outputs) among N requesters.
- Each requester hands over an operand pair through a valid/ready handshake. The arbiter drives the comparator, captures its flags and returns them tagged with the requester id.
- Sits between ALU-side clients and the single comparator instance.

Parameters:
- WIDTH, 4, operand width; must match the comparator.
- N, 4, number of requesters (2..8).
- IDW, 2, id width, equal to clog2(N).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  one-hot grant; a transfer occurs on req_valid[k] & req_ready[k].
- req_a  in  N*WIDTH  operand A, requester k in bits [k*WIDTH +: WIDTH].
- req_b  in  N*WIDTH  operand B, same packing.
- cmp_a  out  WIDTH  to comparator a.
- cmp_b  out  WIDTH  to comparator b.
- cmp_en  out  1  to comparator enable.
- cmp_eq, cmp_gt, cmp_lt  in  1 each  from comparator eq/greater/lesser.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  requester index of the result.
- resp_eq, resp_gt, resp_lt  out  1 each  captured flags.

Behaviour:
- Reset: all outputs are 0 (req_ready, cmp_a, cmp_b, cmp_en, resp_*); state is IDLE; rr_ptr is 0. Reset asserted mid-operation aborts the operation and discards any pending response.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready is combinational, one-hot on the winner when any req_valid is set; all 0 otherwise.
  - Winner: first set req_valid searching rr_ptr, rr_ptr+1, ..., wrapping modulo N.
  - On the edge after a transfer with winner k: cmp_a/cmp_b load req_a[k]/req_b[k]; grant id = k; rr_ptr = (k+1) mod N; cmp_en = 1; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - cmp_en = 1; cmp_a/cmp_b held.
  - On the edge: resp_eq/gt/lt = cmp_eq/gt/lt; resp_id = grant id; resp_valid = 1; cmp_en = 0; go to RESP.
- RESP:
  - resp_valid held until resp_ready = 1.
  - On that edge: resp_valid = 0; go to IDLE.
  - resp_* and cmp_a/cmp_b keep their last values until overwritten.
  - req_ready = 0 throughout ISSUE and RESP.
- Latency: handshake cycle T gives resp_valid high from T+2. Minimum 3 cycles per operation when resp_ready is tied high.
- Requesters must hold req_valid and operands stable until granted. Dropping req_valid before grant is legal and simply withdraws the request.
- Simultaneous requests: only one grant per IDLE cycle; losers keep waiting. A requester granted at k cannot win again until every other active requester has been served.
- rr_ptr wrap: a grant to N-1 sets rr_ptr to 0.
- Flags are passed through unmodified; no arithmetic on operands. Operands are unsigned WIDTH bits.

Optional Feature:
- Macro: CMP_CHECK_EN.
- When defined:
  - Adds output cmp_err (1 bit, reset 0). It is sticky; only rst clears it.
  - cmp_err is set at the ISSUE capture edge if the captured flags are not exactly one-hot.
  - cmp_err is also set if the flags disagree with the arbiter's own compare of cmp_a and cmp_b.
- When undefined: the port and the check logic are absent; behaviour is otherwise identical.

Test Plan:
- Single request: req_valid=4'b0001, A=0011, B=0000. req_ready[0] is high in the same cycle; 2 cycles later resp_valid=1, resp_id=0, gt=1, eq=0, lt=0.
- Equality and less-than:
  - Requester 2 with A=0010, B=0010 gives eq=1, resp_id=2.
  - Requester 1 with A=0001, B=1111 gives lt=1, resp_id=1.
- Round-robin: all four requesters held valid, resp_ready=1. Grant order is 0,1,2,3,0 at intervals of 3 cycles; no requester is granted twice before all others are served.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid. resp_* stay stable, req_ready stays 0, and the pending req_valid[3] is not granted until the cycle after resp_ready=1.
- Reset mid-op: assert rst during ISSUE. All outputs go to 0 immediately, state is IDLE and rr_ptr is 0; the next request (req_valid=4'b1010) grants requester 1.
- CMP_CHECK_EN: model the comparator returning eq=1 and gt=1 for A=1000, B=1000. cmp_err rises at the capture edge and stays 1 until rst.
